// File: rtl/kyber_pkg.sv
// Purpose: shared Kyber constants, transform mode encodings and butterfly address/zeta generation.
// Latency: n/a (package of constants and a pure combinational helper function).
// Backpressure: n/a.
package kyber_pkg;

    localparam int N            = 256;
    localparam int NTT_LAYERS   = 7;
    localparam int BF_PER_LAYER = N / 2;

    localparam logic [1:0] MODE_NTT    = 2'd0;
    localparam logic [1:0] MODE_INTT   = 2'd1;
    localparam logic [1:0] MODE_MULT   = 2'd2;
    localparam logic [1:0] MODE_ADDSUB = 2'd3;

    // One butterfly read command: both coefficient addresses plus the zeta ROM index.
    typedef struct packed {
        logic [7:0] addr_1;
        logic [7:0] addr_2;
        logic [6:0] zeta;
    } rd_cmd_t;

    // Maps (layer, butterfly) to addresses and zeta. The forward transform walks
    // spans 128..2 with rising zeta; the inverse walks spans 2..128 with falling zeta.
    function automatic rd_cmd_t bf_cmd(input logic [2:0] l, input logic [6:0] b, input logic intt);
        int      len;
        int      g;
        int      o;
        int      a1;
        int      z;
        rd_cmd_t c;
        if (!intt) begin
            len = 128 >> l;
            g   = int'(b) >> (7 - int'(l));
            z   = (1 << l) + g;
        end else begin
            len = 2 << l;
            g   = int'(b) >> (int'(l) + 1);
            z   = (128 >> l) - 1 - g;
        end
        o        = int'(b) & (len - 1);
        a1       = 2 * len * g + o;
        c.addr_1 = 8'(a1);
        c.addr_2 = 8'(a1 + len);
        c.zeta   = 7'(z);
        return c;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Purpose: fixed-depth shift register aligning write strobe/addresses with butterfly results.
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none; shifts every cycle.
module ntt_delay_line #(
    parameter int DEPTH = 6,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift every cycle; reset flushes all in-flight entries so no stale write survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Purpose: sequences the 7 layers x 128 butterflies of a Kyber NTT/INTT over one RAM.
// Latency: start to done is 939 cycles; writes trail reads by RD_LAT+BF_LAT cycles.
// Backpressure: none; start is ignored while busy, a drain gap separates layers.
module ntt_ctrl
    import kyber_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_1,
    output logic [7:0] rd_addr_2,
    output logic [6:0] zeta_idx,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_1,
    output logic [7:0] wr_addr_2
);

    localparam int PIPE_LAT = RD_LAT + BF_LAT;
    localparam int DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    layer_q, layer_d;
    logic [6:0]    bf_q, bf_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          rd_en_q;
    rd_cmd_t       cmd_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    bf_mode_q;

    logic          issue_d;
    logic          busy_d;
    rd_cmd_t       cmd_d;
    logic [16:0]   wr_bus;

    // Next-state logic: counters advance one butterfly per ISSUE cycle, DRAIN waits out the pipeline.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        layer_d = layer_q;
        bf_d    = bf_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start && (mode == MODE_NTT || mode == MODE_INTT)) begin
                    state_d = S_ISSUE;
                    mode_d  = mode;
                    layer_d = '0;
                    bf_d    = '0;
                end
            end
            S_ISSUE: begin
                if (bf_q == 7'(BF_PER_LAYER - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    bf_d = bf_q + 7'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(PIPE_LAT - 1)) begin
                    if (layer_q == 3'(NTT_LAYERS - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        layer_d = layer_q + 3'd1;
                        bf_d    = '0;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state so they land registered in the cycle the state is entered.
    always_comb begin
        issue_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        cmd_d   = bf_cmd(layer_d, bf_d, mode_d[0]);
    end

    // State, counters and registered outputs; reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            layer_q   <= '0;
            bf_q      <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            cmd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bf_mode_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            layer_q   <= layer_d;
            bf_q      <= bf_d;
            drain_q   <= drain_d;
            rd_en_q   <= issue_d;
            cmd_q     <= issue_d ? cmd_d : '0;
            busy_q    <= busy_d;
            done_q    <= (state_d == S_FIN);
            bf_mode_q <= busy_d ? mode_d : 2'd0;
        end
    end

    ntt_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (17)
    ) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({rd_en_q, cmd_q.addr_1, cmd_q.addr_2}),
        .q_o (wr_bus)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_1 = cmd_q.addr_1;
    assign rd_addr_2 = cmd_q.addr_2;
    assign zeta_idx  = cmd_q.zeta;
    assign bf_mode   = bf_mode_q;
    assign wr_en     = wr_bus[16];
    assign wr_addr_1 = wr_bus[15:8];
    assign wr_addr_2 = wr_bus[7:0];

endmodule
